// File: rtl/memory_writeback_stage_if.sv
// Data-memory request/grant/response bus between the writeback stage and memory.
interface memory_writeback_stage_if #(parameter int XLEN = 32);
    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [3:0]      dm_be;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [XLEN-1:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/memory_writeback_stage.sv
// Pipeline back end: optional data-memory load/store, then register-file writeback.
// Loads/stores hold ex_ready low until the bus transaction finishes.
module memory_writeback_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] alu_y,
    input  logic [XLEN-1:0] rrd2,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] pc_4,
    input  logic            reg_write,
    input  logic [1:0]      mem_op,
    input  logic [1:0]      mem_size,
    input  logic            mem_unsigned,
    input  logic [1:0]      wb_sel,
    memory_writeback_stage_if.master dm,
    output logic            regwe,
    output logic [4:0]      regwa,
    output logic [XLEN-1:0] regwd,
    output logic            misaligned
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic [1:0]      cap_lane;
    logic [4:0]      cap_rd;
    logic [1:0]      cap_size;
    logic            cap_uns;

    logic            is_load;
    logic            is_store;
    logic            aligned;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;
    logic [XLEN-1:0] wb_val;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_ext;

    assign ex_ready  = (state == IDLE);
    assign dm.dm_req = (state == REQ);

    // Decode the presented operation: alignment, byte enables, lane-replicated store data.
    always_comb begin
        is_load  = (mem_op == 2'b01);
        is_store = (mem_op == 2'b10);
        case (mem_size)
            2'b00: begin
                aligned    = 1'b1;
                be_next    = 4'b0001 << alu_y[1:0];
                wdata_next = {(XLEN/8){rrd2[7:0]}};
            end
            2'b01: begin
                aligned    = ~alu_y[0];
                be_next    = 4'b0011 << alu_y[1:0];
                wdata_next = {(XLEN/16){rrd2[15:0]}};
            end
            default: begin
                aligned    = (alu_y[1:0] == 2'b00);
                be_next    = 4'b1111;
                wdata_next = rrd2;
            end
        endcase
        // Only pc_4 is a real alternative for non-load ops; every other code takes alu_y.
        wb_val = (wb_sel == 2'b10) ? pc_4 : alu_y;
    end

    // Pick the addressed lane out of the load word and sign/zero-extend it.
    always_comb begin
        lane = dm.dm_rdata >> {cap_lane, 3'b000};
        case (cap_size)
            2'b00:   load_ext = {{(XLEN-8){~cap_uns & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{(XLEN-16){~cap_uns & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Control FSM, captured operation, bus outputs and writeback pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cap_lane    <= 2'b00;
            cap_rd      <= 5'd0;
            cap_size    <= 2'b00;
            cap_uns     <= 1'b0;
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= '0;
            dm.dm_wdata <= '0;
            dm.dm_be    <= 4'b0000;
            regwe       <= 1'b0;
            regwa       <= 5'd0;
            regwd       <= '0;
            misaligned  <= 1'b0;
        end else begin
            regwe      <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (is_load || is_store) begin
                            if (aligned) begin
                                state       <= REQ;
                                cap_lane    <= alu_y[1:0];
                                cap_rd      <= rd;
                                cap_size    <= mem_size;
                                cap_uns     <= mem_unsigned;
                                dm.dm_we    <= is_store;
                                dm.dm_addr  <= {alu_y[XLEN-1:2], 2'b00};
                                dm.dm_wdata <= wdata_next;
                                dm.dm_be    <= be_next;
                            end else begin
                                // Misaligned accesses are dropped: no bus traffic, no writeback.
                                misaligned <= 1'b1;
                            end
                        end else begin
                            regwe <= reg_write && (rd != 5'd0);
                            regwa <= rd;
                            regwd <= wb_val;
                        end
                    end
                end
                REQ: begin
                    if (dm.dm_gnt)
                        state <= dm.dm_we ? IDLE : RESP;
                end
                RESP: begin
                    if (dm.dm_rvalid) begin
                        state <= IDLE;
                        regwe <= (cap_rd != 5'd0);
                        regwa <= cap_rd;
                        regwd <= load_ext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Directed bench for memory_writeback_stage with hand-computed expectations.
module tb_memory_writeback_stage;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_y, rrd2, pc_4;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  mem_op, mem_size, wb_sel;
    logic        mem_unsigned;
    logic        regwe;
    logic [4:0]  regwa;
    logic [31:0] regwd;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    memory_writeback_stage_if #(.XLEN(32)) bus ();

    memory_writeback_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_y(alu_y), .rrd2(rrd2), .rd(rd), .pc_4(pc_4),
        .reg_write(reg_write), .mem_op(mem_op), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .wb_sel(wb_sel),
        .dm(bus.master),
        .regwe(regwe), .regwa(regwa), .regwd(regwd), .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                         input logic we, input logic [1:0] sel);
        ex_valid     = 1'b1;
        mem_op       = op;
        mem_size     = sz;
        mem_unsigned = uns;
        alu_y        = a;
        rrd2         = d;
        rd           = r;
        reg_write    = we;
        wb_sel       = sel;
    endtask

    // Full load: accept, grant after gd cycles, rvalid rv cycles after grant; counts ex_ready-low cycles.
    task automatic do_load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                           input logic [4:0] r, input int gd, input int rv,
                           input logic [31:0] data, output int busy);
        busy = 0;
        drive(2'b01, sz, uns, a, 32'h0, r, 1'b1, 2'b01);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < gd; i++) begin
            if (!ex_ready) busy++;
            step();
        end
        bus.dm_gnt = 1'b1;
        if (!ex_ready) busy++;
        step();
        bus.dm_gnt = 1'b0;
        for (int i = 0; i < rv; i++) begin
            if (!ex_ready) busy++;
            step();
        end
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = data;
        if (!ex_ready) busy++;
        step();
        bus.dm_rvalid = 1'b0;
    endtask

    initial begin
        int busy;
        int reqs;
        reset = 1'b0;
        ex_valid = 1'b0; alu_y = '0; rrd2 = '0; pc_4 = '0; rd = '0;
        reg_write = 1'b0; mem_op = '0; mem_size = '0; mem_unsigned = 1'b0; wb_sel = '0;
        bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0; bus.dm_rdata = '0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_ready", {31'b0, ex_ready}, 32'h1);
        chk("rst_dm_req", {31'b0, bus.dm_req}, 32'h0);
        chk("rst_dm_we", {31'b0, bus.dm_we}, 32'h0);
        chk("rst_dm_addr", bus.dm_addr, 32'h0);
        chk("rst_dm_wdata", bus.dm_wdata, 32'h0);
        chk("rst_dm_be", {28'b0, bus.dm_be}, 32'h0);
        chk("rst_regwe", {31'b0, regwe}, 32'h0);
        chk("rst_regwa", {27'b0, regwa}, 32'h0);
        chk("rst_regwd", regwd, 32'h0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
        reset = 1'b0;
        step();

        // Back-to-back ALU ops, x0 suppressed, pc_4 link select.
        drive(2'b00, 2'b10, 1'b0, 32'h11, 32'h0, 5'd5, 1'b1, 2'b00);
        step();
        chk("alu1_regwe", {31'b0, regwe}, 32'h1);
        chk("alu1_regwa", {27'b0, regwa}, 32'd5);
        chk("alu1_regwd", regwd, 32'h11);
        chk("alu1_ready", {31'b0, ex_ready}, 32'h1);
        drive(2'b00, 2'b10, 1'b0, 32'h22, 32'h0, 5'd6, 1'b1, 2'b00);
        step();
        chk("alu2_regwe", {31'b0, regwe}, 32'h1);
        chk("alu2_regwa", {27'b0, regwa}, 32'd6);
        chk("alu2_regwd", regwd, 32'h22);
        chk("alu2_ready", {31'b0, ex_ready}, 32'h1);
        drive(2'b00, 2'b10, 1'b0, 32'h33, 32'h0, 5'd0, 1'b1, 2'b00);
        step();
        chk("alu_x0_regwe", {31'b0, regwe}, 32'h0);
        chk("alu3_ready", {31'b0, ex_ready}, 32'h1);
        drive(2'b00, 2'b10, 1'b0, 32'h99, 32'h0, 5'd7, 1'b1, 2'b10);
        pc_4 = 32'h44;
        step();
        chk("link_regwe", {31'b0, regwe}, 32'h1);
        chk("link_regwd", regwd, 32'h44);
        ex_valid = 1'b0;
        step();
        chk("idle_regwe", {31'b0, regwe}, 32'h0);
        chk("hold_regwd", regwd, 32'h44);

        // Store byte, grant delayed 3 cycles: request held 4 cycles.
        drive(2'b10, 2'b00, 1'b0, 32'h1003, 32'h0000_00AB, 5'd9, 1'b0, 2'b00);
        step();
        ex_valid = 1'b0;
        chk("sb_be", {28'b0, bus.dm_be}, 32'h8);
        chk("sb_wdata", bus.dm_wdata, 32'hABAB_ABAB);
        chk("sb_addr", bus.dm_addr, 32'h1000);
        chk("sb_we", {31'b0, bus.dm_we}, 32'h1);
        chk("sb_ready_low", {31'b0, ex_ready}, 32'h0);
        reqs = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.dm_req) reqs++;
            step();
        end
        bus.dm_gnt = 1'b1;
        if (bus.dm_req) reqs++;
        step();
        bus.dm_gnt = 1'b0;
        chk("sb_req_cycles", reqs, 32'd4);
        chk("sb_req_drop", {31'b0, bus.dm_req}, 32'h0);
        chk("sb_ready_back", {31'b0, ex_ready}, 32'h1);
        chk("sb_no_regwe", {31'b0, regwe}, 32'h0);

        // Load half signed, then unsigned, from upper lane.
        drive(2'b01, 2'b01, 1'b0, 32'h2002, 32'h0, 5'd8, 1'b1, 2'b01);
        step();
        ex_valid = 1'b0;
        chk("lh_be", {28'b0, bus.dm_be}, 32'hC);
        chk("lh_addr", bus.dm_addr, 32'h2000);
        chk("lh_we", {31'b0, bus.dm_we}, 32'h0);
        chk("lh_req", {31'b0, bus.dm_req}, 32'h1);
        bus.dm_gnt = 1'b1;
        step();
        bus.dm_gnt = 1'b0;
        chk("lh_resp_req", {31'b0, bus.dm_req}, 32'h0);
        chk("lh_resp_ready", {31'b0, ex_ready}, 32'h0);
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'h8001_7FFF;
        step();
        bus.dm_rvalid = 1'b0;
        chk("lh_regwe", {31'b0, regwe}, 32'h1);
        chk("lh_regwa", {27'b0, regwa}, 32'd8);
        chk("lh_regwd", regwd, 32'hFFFF_8001);
        do_load(2'b01, 1'b1, 32'h2002, 5'd8, 0, 0, 32'h8001_7FFF, busy);
        chk("lhu_regwd", regwd, 32'h0000_8001);
        do_load(2'b00, 1'b0, 32'h2001, 5'd3, 1, 0, 32'h1234_F678, busy);
        chk("lb_regwd", regwd, 32'hFFFF_FFF6);

        // Load word: grant immediate, rvalid two cycles after the grant cycle.
        do_load(2'b10, 1'b0, 32'h100, 5'd10, 0, 1, 32'hDEAD_BEEF, busy);
        chk("lw_busy", busy, 32'd3);
        chk("lw_regwe", {31'b0, regwe}, 32'h1);
        chk("lw_regwa", {27'b0, regwa}, 32'd10);
        chk("lw_regwd", regwd, 32'hDEAD_BEEF);
        chk("lw_ready", {31'b0, ex_ready}, 32'h1);
        step();
        chk("lw_pulse_end", {31'b0, regwe}, 32'h0);
        chk("lw_hold", regwd, 32'hDEAD_BEEF);

        // Misaligned word load is dropped.
        drive(2'b01, 2'b10, 1'b0, 32'h102, 32'h0, 5'd4, 1'b1, 2'b01);
        step();
        ex_valid = 1'b0;
        chk("mis_pulse", {31'b0, misaligned}, 32'h1);
        chk("mis_req", {31'b0, bus.dm_req}, 32'h0);
        chk("mis_regwe", {31'b0, regwe}, 32'h0);
        chk("mis_ready", {31'b0, ex_ready}, 32'h1);
        step();
        chk("mis_pulse_end", {31'b0, misaligned}, 32'h0);
        chk("mis_req2", {31'b0, bus.dm_req}, 32'h0);

        // Reset during RESP abandons the load.
        drive(2'b01, 2'b10, 1'b0, 32'h200, 32'h0, 5'd11, 1'b1, 2'b01);
        step();
        ex_valid = 1'b0;
        bus.dm_gnt = 1'b1;
        step();
        bus.dm_gnt = 1'b0;
        chk("rl_in_resp", {31'b0, ex_ready}, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("rl_ready", {31'b0, ex_ready}, 32'h1);
        chk("rl_req", {31'b0, bus.dm_req}, 32'h0);
        chk("rl_addr", bus.dm_addr, 32'h0);
        chk("rl_be", {28'b0, bus.dm_be}, 32'h0);
        chk("rl_regwe", {31'b0, regwe}, 32'h0);
        chk("rl_regwd", regwd, 32'h0);
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'hCAFE_F00D;
        step();
        reset = 1'b0;
        step();
        bus.dm_rvalid = 1'b0;
        chk("rl_no_wb", {31'b0, regwe}, 32'h0);
        chk("rl_regwa", {27'b0, regwa}, 32'h0);
        drive(2'b00, 2'b10, 1'b0, 32'h55, 32'h0, 5'd12, 1'b1, 2'b00);
        step();
        ex_valid = 1'b0;
        chk("post_regwe", {31'b0, regwe}, 32'h1);
        chk("post_regwa", {27'b0, regwa}, 32'd12);
        chk("post_regwd", regwd, 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
